cpu_issue_queue: RTL and testbench
==================================

CPU_ISSUE_QUEUE -- requirements
Module: cpu_issue_queue

Interface
REQ-001: cpu_clock_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-002: cpu_reset_n_i  input  1  reset, synchronous, active-low.
REQ-003: flush_i  input  1  pipeline flush; discards all queued and in-flight issue state.
REQ-004: enq_valid_i  input  1  enqueue request for one micro-op this cycle.
REQ-005: enq_rob_i  input  5  ROB id of the enqueued micro-op.
REQ-006: enq_rs1_i / enq_rs2_i  input  6 each  physical source tags.
REQ-007: enq_rs1_rdy_i / enq_rs2_rdy_i  input  1 each  source already ready at enqueue.
REQ-008: wk0_valid_i, wk0_tag_i / wk1_valid_i, wk1_tag_i  input  1+6 each  two wakeup (writeback broadcast) ports.
REQ-009: full_o  output  1  queue holds 8 entries; enqueue not accepted.
REQ-010: data_o  output  18  issue packet {rs2[17:12], rs1[11:6], 1'b0 [5], rob[4:0]}, consumed by the operand-read/dispatch stage.
REQ-011: valid_o  output  1  data_o holds an issued micro-op this cycle.

Function
REQ-012: The queue SHALL hold 8 entries: valid, rob[4:0], rs1[5:0], rs1_rdy, rs2[5:0], rs2_rdy. Slot 0 is always the oldest.
REQ-013: The queue SHALL be collapsing: entries stay in age order, and valid entries occupy slots 0..count-1 with no holes.
REQ-014: count SHALL be a 4-bit value in the range 0..8; full_o = (count == 8), driven combinationally from count.
REQ-015: Enqueue SHALL be accepted iff enq_valid_i & !full_o & !flush_i.
  - An accepted entry is written to the first free slot, after accounting for this cycle's issue collapse.
REQ-016: Enqueue while full_o = 1 SHALL be ignored; the upstream stage is responsible for holding the request.
REQ-017: A source whose tag equals 6'd0 SHALL be treated as ready regardless of its rdy bit.
REQ-018: Each cycle, wakeup SHALL set rsX_rdy on every valid entry whose rsX equals wk0_tag_i (when wk0_valid_i) or wk1_tag_i (when wk1_valid_i).
REQ-019: Wakeup SHALL also apply to the micro-op enqueued in the same cycle.
  - The stored rdy bit = enq_rdy | tag match.
REQ-020: An entry is eligible when it is valid & rs1_rdy & rs2_rdy. Readiness gained by wakeup in cycle N makes the entry eligible for selection in cycle N+1.
REQ-021: Select SHALL pick the lowest-index (oldest) eligible entry, at most one per cycle.
REQ-022: On selection, the entry SHALL be removed and entries above it shift down by one in the same edge.
REQ-023: The selected entry's fields SHALL be registered to data_o with valid_o = 1 on the next edge: issue latency of 1 cycle from eligibility.
REQ-024: When no entry is eligible, valid_o SHALL be 0 on the next edge and data_o SHALL hold its previous value.
REQ-025: Simultaneous enqueue and issue SHALL be allowed and SHALL update count as count + 1 − 1.
REQ-026: When count = 8 and an issue occurs, enqueue SHALL still be refused that cycle because full_o was 1.
REQ-027: There SHALL be no backpressure on data_o/valid_o: the consumer accepts every issued packet.
REQ-028: A flush_i = 1 cycle SHALL, on that edge:
  - clear all entry valid bits;
  - set count to 0;
  - force valid_o to 0;
  - perform no enqueue and no issue.
  Flush takes priority over enqueue, wakeup and select.
REQ-029: data_o[5] SHALL always be 0.

Reset
REQ-030: When cpu_reset_n_i = 0 at an edge, the following SHALL be cleared: all entry valid bits, count = 0, valid_o = 0, data_o = 18'd0, full_o = 0. This takes priority over flush_i and all other inputs.
REQ-031: While reset is active, enq_valid_i and wakeup ports SHALL be ignored. The first enqueue SHALL be accepted on the first edge with cpu_reset_n_i = 1.

Verification
REQ-032: Enqueue rob=3, rs1=5 (rdy), rs2=0 (rdy=0) in cycle 0 -> valid_o=1, data_o={6'd0,6'd5,1'b0,5'd3} at cycle 1.
REQ-033: Enqueue rob=1 (rs1=7 not ready), then rob=2 (all ready) -> rob=2 issues first; wk0 tag=7 in cycle 3 -> rob=1 issued at edge ending cycle 4.
REQ-034: Enqueue in cycle 0 with rs1=9 not ready while wk1_valid_i=1, wk1_tag_i=9 in the same cycle -> entry issues at cycle 1.
REQ-035: Fill 8 unready entries -> full_o=1; 9th enqueue ignored; wakeup of entry 0 -> it issues, full_o drops, next enqueue accepted.
REQ-036: Flush asserted with 5 entries queued and valid_o=1 -> next cycle count=0, valid_o=0, full_o=0.
REQ-037: Reset asserted mid-operation with 4 entries and an enqueue pending -> valid_o=0, data_o=0, queue empty after that edge.

Source files
------------

// File: rtl/cpu_issue_queue.sv
// rtl/cpu_issue_queue.sv - 8-entry collapsing issue queue with dual wakeup and oldest-first select
module cpu_issue_queue (
    input  logic        cpu_clock_i,
    input  logic        cpu_reset_n_i,
    input  logic        flush_i,
    input  logic        enq_valid_i,
    input  logic [4:0]  enq_rob_i,
    input  logic [5:0]  enq_rs1_i,
    input  logic [5:0]  enq_rs2_i,
    input  logic        enq_rs1_rdy_i,
    input  logic        enq_rs2_rdy_i,
    input  logic        wk0_valid_i,
    input  logic [5:0]  wk0_tag_i,
    input  logic        wk1_valid_i,
    input  logic [5:0]  wk1_tag_i,
    output logic        full_o,
    output logic [17:0] data_o,
    output logic        valid_o
);
    localparam int N = 8;

    logic [N-1:0] ent_valid_q, ent_valid_d;
    logic [N-1:0] rdy1_q, rdy1_d, rdy2_q, rdy2_d;
    logic [4:0]   rob_q [N];
    logic [4:0]   rob_d [N];
    logic [5:0]   rs1_q [N];
    logic [5:0]   rs1_d [N];
    logic [5:0]   rs2_q [N];
    logic [5:0]   rs2_d [N];
    logic [3:0]   count_q, count_d, count_after;
    logic [17:0]  data_q, data_d;
    logic         valid_q, valid_d;
    logic         sel_found, enq_ok, shift;
    logic [2:0]   sel_idx, src;

    assign full_o  = (count_q == 4'd8);
    assign data_o  = data_q;
    assign valid_o = valid_q;

    always_comb begin
        sel_found   = 1'b0;
        sel_idx     = 3'd0;
        shift       = 1'b0;
        src         = 3'd0;
        ent_valid_d = '0;
        rdy1_d      = '0;
        rdy2_d      = '0;
        for (int i = 0; i < N; i++) begin
            rob_d[i] = 5'd0;
            rs1_d[i] = 6'd0;
            rs2_d[i] = 6'd0;
        end

        for (int i = 0; i < N; i++) begin
            if (!sel_found && ent_valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = 3'(i);
            end
        end

        count_after = count_q - {3'b000, sel_found};
        enq_ok      = enq_valid_i && !full_o && !flush_i;

        // Collapse above the selected slot, apply wakeup, then drop the new op into the first free slot.
        for (int i = 0; i < N; i++) begin
            shift = sel_found && (3'(i) >= sel_idx);
            if (!(shift && i == N - 1)) begin
                src            = shift ? 3'(i + 1) : 3'(i);
                ent_valid_d[i] = ent_valid_q[src];
                rob_d[i]       = rob_q[src];
                rs1_d[i]       = rs1_q[src];
                rs2_d[i]       = rs2_q[src];
                rdy1_d[i]      = rdy1_q[src]
                               | (wk0_valid_i && rs1_q[src] == wk0_tag_i)
                               | (wk1_valid_i && rs1_q[src] == wk1_tag_i);
                rdy2_d[i]      = rdy2_q[src]
                               | (wk0_valid_i && rs2_q[src] == wk0_tag_i)
                               | (wk1_valid_i && rs2_q[src] == wk1_tag_i);
            end
            if (enq_ok && 4'(i) == count_after) begin
                ent_valid_d[i] = 1'b1;
                rob_d[i]       = enq_rob_i;
                rs1_d[i]       = enq_rs1_i;
                rs2_d[i]       = enq_rs2_i;
                rdy1_d[i]      = enq_rs1_rdy_i || (enq_rs1_i == 6'd0)
                               || (wk0_valid_i && enq_rs1_i == wk0_tag_i)
                               || (wk1_valid_i && enq_rs1_i == wk1_tag_i);
                rdy2_d[i]      = enq_rs2_rdy_i || (enq_rs2_i == 6'd0)
                               || (wk0_valid_i && enq_rs2_i == wk0_tag_i)
                               || (wk1_valid_i && enq_rs2_i == wk1_tag_i);
            end
        end

        count_d = count_after + {3'b000, enq_ok};
        valid_d = sel_found;
        data_d  = sel_found ? {rs2_q[sel_idx], rs1_q[sel_idx], 1'b0, rob_q[sel_idx]} : data_q;
    end

    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_reset_n_i) begin
            ent_valid_q <= '0;
            count_q     <= 4'd0;
            valid_q     <= 1'b0;
            data_q      <= 18'd0;
        end else if (flush_i) begin
            ent_valid_q <= '0;
            count_q     <= 4'd0;
            valid_q     <= 1'b0;
        end else begin
            ent_valid_q <= ent_valid_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            data_q      <= data_d;
        end
    end

    always_ff @(posedge cpu_clock_i) begin
        rdy1_q <= rdy1_d;
        rdy2_q <= rdy2_d;
        for (int i = 0; i < N; i++) begin
            rob_q[i] <= rob_d[i];
            rs1_q[i] <= rs1_d[i];
            rs2_q[i] <= rs2_d[i];
        end
    end
endmodule

// File: tb/tb_cpu_issue_queue.sv
// tb/tb_cpu_issue_queue.sv - randomized bench for cpu_issue_queue against a queue-based reference model
module tb_cpu_issue_queue;
    logic        clk = 1'b0;
    logic        rst_n, flush, enq_valid, enq_rs1_rdy, enq_rs2_rdy;
    logic        wk0_valid, wk1_valid;
    logic [4:0]  enq_rob;
    logic [5:0]  enq_rs1, enq_rs2, wk0_tag, wk1_tag;
    logic        full_o, valid_o;
    logic [17:0] data_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] rob;
        logic [5:0] rs1;
        logic       r1;
        logic [5:0] rs2;
        logic       r2;
    } ent_t;

    ent_t        mq[$];
    logic        m_valid = 1'b0;
    logic [17:0] m_data = 18'd0;

    always #5 clk = ~clk;

    cpu_issue_queue dut (
        .cpu_clock_i   (clk),
        .cpu_reset_n_i (rst_n),
        .flush_i       (flush),
        .enq_valid_i   (enq_valid),
        .enq_rob_i     (enq_rob),
        .enq_rs1_i     (enq_rs1),
        .enq_rs2_i     (enq_rs2),
        .enq_rs1_rdy_i (enq_rs1_rdy),
        .enq_rs2_rdy_i (enq_rs2_rdy),
        .wk0_valid_i   (wk0_valid),
        .wk0_tag_i     (wk0_tag),
        .wk1_valid_i   (wk1_valid),
        .wk1_tag_i     (wk1_tag),
        .full_o        (full_o),
        .data_o        (data_o),
        .valid_o       (valid_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic woken(input logic [5:0] tag);
        return (wk0_valid && tag == wk0_tag) || (wk1_valid && tag == wk1_tag);
    endfunction

    // A tag of zero is always ready, so readiness is judged at select time from the raw bit.
    task automatic model_step();
        int   pre;
        int   sel;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
            m_valid = 1'b0;
            m_data  = 18'd0;
        end else if (flush) begin
            mq.delete();
            m_valid = 1'b0;
        end else begin
            pre = mq.size();
            sel = -1;
            foreach (mq[i])
                if (sel < 0 && (mq[i].r1 || mq[i].rs1 == 0) && (mq[i].r2 || mq[i].rs2 == 0))
                    sel = i;
            foreach (mq[i]) begin
                mq[i].r1 = mq[i].r1 | woken(mq[i].rs1);
                mq[i].r2 = mq[i].r2 | woken(mq[i].rs2);
            end
            if (sel >= 0) begin
                m_data  = {mq[sel].rs2, mq[sel].rs1, 1'b0, mq[sel].rob};
                m_valid = 1'b1;
                mq.delete(sel);
            end else begin
                m_valid = 1'b0;
            end
            if (enq_valid && pre < 8) begin
                e.rob = enq_rob;
                e.rs1 = enq_rs1;
                e.rs2 = enq_rs2;
                e.r1  = enq_rs1_rdy | woken(enq_rs1);
                e.r2  = enq_rs2_rdy | woken(enq_rs2);
                mq.push_back(e);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        check("valid_o", {31'd0, valid_o}, {31'd0, m_valid});
        check("full_o", {31'd0, full_o}, {31'd0, mq.size() == 8});
        check("data_o", {14'd0, data_o}, {14'd0, m_data});
    endtask

    task automatic idle();
        rst_n = 1'b1; flush = 1'b0; enq_valid = 1'b0;
        enq_rob = 5'd0; enq_rs1 = 6'd0; enq_rs2 = 6'd0;
        enq_rs1_rdy = 1'b0; enq_rs2_rdy = 1'b0;
        wk0_valid = 1'b0; wk0_tag = 6'd0; wk1_valid = 1'b0; wk1_tag = 6'd0;
    endtask

    task automatic enq(input logic [4:0] rob, input logic [5:0] rs1, input logic r1,
                       input logic [5:0] rs2, input logic r2);
        idle();
        enq_valid = 1'b1; enq_rob = rob;
        enq_rs1 = rs1; enq_rs1_rdy = r1; enq_rs2 = rs2; enq_rs2_rdy = r2;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        enq_valid = 1'b1; enq_rs1_rdy = 1'b1; enq_rs2_rdy = 1'b1;
        step();
        step();
        check("reset_valid", {31'd0, valid_o}, 32'd0);
        check("reset_data", {14'd0, data_o}, 32'd0);

        enq(5'd3, 6'd5, 1'b1, 6'd0, 1'b0); step();
        idle(); step();
        check("r032_data", {14'd0, data_o}, 32'h143);

        enq(5'd1, 6'd7, 1'b0, 6'd0, 1'b1); step();
        enq(5'd2, 6'd4, 1'b1, 6'd4, 1'b1); step();
        idle(); step();
        check("r033_first", {27'd0, data_o[4:0]}, 32'd2);
        step();
        wk0_valid = 1'b1; wk0_tag = 6'd7; step();
        idle(); step();
        check("r033_second", {26'd0, valid_o, data_o[4:0]}, 32'h21);

        enq(5'd9, 6'd9, 1'b0, 6'd0, 1'b0);
        wk1_valid = 1'b1; wk1_tag = 6'd9; step();
        idle(); step();
        check("r034_issue", {26'd0, valid_o, data_o[4:0]}, 32'h29);

        for (int i = 0; i < 8; i++) begin
            enq(5'(i + 10), 6'(i + 10), 1'b0, 6'd0, 1'b0); step();
        end
        check("r035_full", {31'd0, full_o}, 32'd1);
        enq(5'd30, 6'd0, 1'b1, 6'd0, 1'b1); step();
        idle(); wk0_valid = 1'b1; wk0_tag = 6'd10; step();
        idle(); step();
        check("r035_drop", {30'd0, full_o, valid_o}, 32'd1);
        enq(5'd31, 6'd0, 1'b1, 6'd0, 1'b1); step();
        idle(); flush = 1'b1; step();
        check("r036_flush", {30'd0, full_o, valid_o}, 32'd0);

        for (int i = 0; i < 4; i++) begin
            enq(5'(i), 6'(i + 20), 1'b0, 6'd0, 1'b1); step();
        end
        enq(5'd7, 6'd0, 1'b1, 6'd0, 1'b1); rst_n = 1'b0; step();
        check("r037_reset", {13'd0, valid_o, data_o}, 32'd0);

        for (int n = 0; n < 3000; n++) begin
            idle();
            rst_n       = ($urandom_range(0, 199) != 0);
            flush       = ($urandom_range(0, 49) == 0);
            enq_valid   = ($urandom_range(0, 9) < 6);
            enq_rob     = 5'($urandom);
            enq_rs1     = 6'($urandom_range(0, 15));
            enq_rs2     = 6'($urandom_range(0, 15));
            enq_rs1_rdy = ($urandom_range(0, 3) == 0);
            enq_rs2_rdy = ($urandom_range(0, 3) == 0);
            wk0_valid   = ($urandom_range(0, 9) < 3);
            wk0_tag     = 6'($urandom_range(1, 15));
            wk1_valid   = ($urandom_range(0, 9) < 2);
            wk1_tag     = 6'($urandom_range(1, 15));
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
